// File: rtl/wb_regfile_pkg.sv
// Shared encodings for the write-back stage and register file.
// Holds the RegDst/MemToReg select codes and the fixed architectural register indices.
package wb_regfile_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] REGDST_RT   = 2'd0;
  localparam logic [1:0] REGDST_RD   = 2'd1;
  localparam logic [1:0] REGDST_LINK = 2'd2;

  localparam logic [1:0] MEMTOREG_ALU = 2'd0;
  localparam logic [1:0] MEMTOREG_MEM = 2'd1;
  localparam logic [1:0] MEMTOREG_PC4 = 2'd2;

  localparam logic [REG_AW-1:0] ZERO = 5'd0;
  localparam logic [REG_AW-1:0] SP   = 5'd29;
  localparam logic [REG_AW-1:0] RA   = 5'd31;

endpackage

// File: rtl/wb_regfile_reg_array_2r1w.sv
// Two-read/one-write register array with hardwired $0; write latency 1 edge, reads combinational, no backpressure.
// REGFILE_BYPASS_EN makes a same-cycle read of the write target return the write data.
module reg_array_2r1w
  import wb_regfile_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                NUM_REGS = 32,
  parameter logic [REG_AW-1:0] SP_REG   = SP,
  parameter logic [DATA_W-1:0] SP_INIT  = 32'h0000_03FC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_dat,
  input  logic [REG_AW-1:0] rd_addr_a,
  input  logic [REG_AW-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_dat_a,
  output logic [DATA_W-1:0] rd_dat_b
);

  // $0 has no storage; index 0 is never allocated.
  logic [DATA_W-1:0] regs [1:NUM_REGS-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < NUM_REGS; i++)
        regs[i] <= (i == int'(SP_REG)) ? SP_INIT : '0;
    end else if (wr_en && wr_addr != ZERO) begin
      regs[wr_addr] <= wr_dat;
    end
  end

  always_comb begin
    rd_dat_a = (rd_addr_a == ZERO) ? '0 : regs[rd_addr_a];
    rd_dat_b = (rd_addr_b == ZERO) ? '0 : regs[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && wr_addr != ZERO && rd_addr_a == wr_addr) rd_dat_a = wr_dat;
    if (wr_en && wr_addr != ZERO && rd_addr_b == wr_addr) rd_dat_b = wr_dat;
`endif
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back select + 32-entry register file commit, last-write record and commit counter.
// Latency: write commits on the next edge, selects/reads combinational; no backpressure. Optional REGFILE_BYPASS_EN.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                NUM_REGS = 32,
  parameter logic [REG_AW-1:0] LINK_REG = RA,
  parameter logic [REG_AW-1:0] SP_REG   = SP,
  parameter logic [DATA_W-1:0] SP_INIT  = 32'h0000_03FC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] PC_add_4_in,
  input  logic [DATA_W-1:0] ALUOut_in,
  input  logic [DATA_W-1:0] MemReadData_in,
  input  logic [REG_AW-1:0] Rt_in,
  input  logic [REG_AW-1:0] Rd_in,
  input  logic [1:0]        RegDst_in,
  input  logic [1:0]        MemToReg_in,
  input  logic              RegWrite_in,
  input  logic [REG_AW-1:0] ReadAddrA,
  input  logic [REG_AW-1:0] ReadAddrB,
  output logic [DATA_W-1:0] ReadDataA,
  output logic [DATA_W-1:0] ReadDataB,
  output logic [REG_AW-1:0] WB_Addr_out,
  output logic [DATA_W-1:0] WB_Data_out,
  output logic              WB_En_out,
  output logic [REG_AW-1:0] LastWrAddr_out,
  output logic [DATA_W-1:0] LastWrData_out,
  output logic              LastWrEn_out,
  output logic [31:0]       WriteCount_out
);

  always_comb begin
    WB_Addr_out = LINK_REG;
    case (RegDst_in)
      REGDST_RT:         WB_Addr_out = Rt_in;
      REGDST_RD:         WB_Addr_out = Rd_in;
      REGDST_LINK, 2'd3: WB_Addr_out = LINK_REG;
      default:           WB_Addr_out = LINK_REG;
    endcase
  end

  always_comb begin
    WB_Data_out = PC_add_4_in;
    case (MemToReg_in)
      MEMTOREG_ALU:       WB_Data_out = ALUOut_in;
      MEMTOREG_MEM:       WB_Data_out = MemReadData_in;
      MEMTOREG_PC4, 2'd3: WB_Data_out = PC_add_4_in;
      default:            WB_Data_out = PC_add_4_in;
    endcase
  end

  // Reset is deliberately not folded in here; the commit paths gate it themselves.
  assign WB_En_out = RegWrite_in && (WB_Addr_out != ZERO);

  reg_array_2r1w #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .SP_REG   (SP_REG),
    .SP_INIT  (SP_INIT)
  ) u_regs (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (WB_En_out),
    .wr_addr   (WB_Addr_out),
    .wr_dat    (WB_Data_out),
    .rd_addr_a (ReadAddrA),
    .rd_addr_b (ReadAddrB),
    .rd_dat_a  (ReadDataA),
    .rd_dat_b  (ReadDataB)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      LastWrAddr_out <= '0;
      LastWrData_out <= '0;
      LastWrEn_out   <= 1'b0;
      WriteCount_out <= '0;
    end else if (WB_En_out) begin
      LastWrAddr_out <= WB_Addr_out;
      LastWrData_out <= WB_Data_out;
      LastWrEn_out   <= 1'b1;
      WriteCount_out <= WriteCount_out + 32'd1;
    end else begin
      LastWrEn_out   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile; expected values are hand-computed constants.
// Same-cycle read expectation follows REGFILE_BYPASS_EN.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PC_add_4_in, ALUOut_in, MemReadData_in;
  logic [4:0]  Rt_in, Rd_in;
  logic [1:0]  RegDst_in, MemToReg_in;
  logic        RegWrite_in;
  logic [4:0]  ReadAddrA, ReadAddrB;
  logic [31:0] ReadDataA, ReadDataB;
  logic [4:0]  WB_Addr_out;
  logic [31:0] WB_Data_out;
  logic        WB_En_out;
  logic [4:0]  LastWrAddr_out;
  logic [31:0] LastWrData_out;
  logic        LastWrEn_out;
  logic [31:0] WriteCount_out;

  int err_cnt = 0;
  int chk_cnt = 0;

  wb_regfile dut (
    .clk            (clk),
    .reset          (reset),
    .PC_add_4_in    (PC_add_4_in),
    .ALUOut_in      (ALUOut_in),
    .MemReadData_in (MemReadData_in),
    .Rt_in          (Rt_in),
    .Rd_in          (Rd_in),
    .RegDst_in      (RegDst_in),
    .MemToReg_in    (MemToReg_in),
    .RegWrite_in    (RegWrite_in),
    .ReadAddrA      (ReadAddrA),
    .ReadAddrB      (ReadAddrB),
    .ReadDataA      (ReadDataA),
    .ReadDataB      (ReadDataB),
    .WB_Addr_out    (WB_Addr_out),
    .WB_Data_out    (WB_Data_out),
    .WB_En_out      (WB_En_out),
    .LastWrAddr_out (LastWrAddr_out),
    .LastWrData_out (LastWrData_out),
    .LastWrEn_out   (LastWrEn_out),
    .WriteCount_out (WriteCount_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RegWrite_in    = 1'b0;
    RegDst_in      = 2'd0;
    MemToReg_in    = 2'd0;
    Rt_in          = 5'd0;
    Rd_in          = 5'd0;
    ALUOut_in      = 32'h0;
    MemReadData_in = 32'h0;
    PC_add_4_in    = 32'h0;
  endtask

  task automatic wr(input logic [1:0] dst, input logic [4:0] rt, input logic [4:0] rd,
                    input logic [1:0] m2r, input logic [31:0] alu, input logic [31:0] mem,
                    input logic [31:0] pc4);
    RegDst_in = dst; Rt_in = rt; Rd_in = rd; MemToReg_in = m2r;
    ALUOut_in = alu; MemReadData_in = mem; PC_add_4_in = pc4;
    RegWrite_in = 1'b1;
  endtask

  initial begin
    logic [31:0] same_cycle_exp;
    idle();
    reset = 1'b1;
    ReadAddrA = 5'd29;
    ReadAddrB = 5'd5;
    tick();
    reset = 1'b0;
    #2;
    chk("rst_sp", ReadDataA, 32'h0000_03FC);
    chk("rst_r5", ReadDataB, 32'h0);
    chk("rst_cnt", WriteCount_out, 32'h0);
    chk("rst_last_en", {31'h0, LastWrEn_out}, 32'h0);
    chk("rst_last_addr", {27'h0, LastWrAddr_out}, 32'h0);

    // Rd select, ALU data
    wr(2'd1, 5'd3, 5'd8, 2'd0, 32'hDEAD_BEEF, 32'h1111_1111, 32'h2222_2222);
    #2;
    chk("sel_rd_addr", {27'h0, WB_Addr_out}, 32'd8);
    chk("sel_alu_data", WB_Data_out, 32'hDEAD_BEEF);
    chk("sel_rd_en", {31'h0, WB_En_out}, 32'h1);
    tick();
    idle();
    ReadAddrA = 5'd8;
    #2;
    chk("r8", ReadDataA, 32'hDEAD_BEEF);
    chk("w1_last_addr", {27'h0, LastWrAddr_out}, 32'd8);
    chk("w1_last_data", LastWrData_out, 32'hDEAD_BEEF);
    chk("w1_last_en", {31'h0, LastWrEn_out}, 32'h1);
    chk("w1_cnt", WriteCount_out, 32'd1);

    // Link: RegDst=2, MemToReg=2
    wr(2'd2, 5'd4, 5'd6, 2'd2, 32'h3333_3333, 32'h4444_4444, 32'h0000_0044);
    #2;
    chk("sel_link_addr", {27'h0, WB_Addr_out}, 32'd31);
    chk("sel_pc4_data", WB_Data_out, 32'h0000_0044);
    tick();
    idle();
    ReadAddrA = 5'd31;
    #2;
    chk("r31", ReadDataA, 32'h0000_0044);
    chk("w2_cnt", WriteCount_out, 32'd2);
    chk("w2_last_addr", {27'h0, LastWrAddr_out}, 32'd31);

    // Write to $0 is dropped
    wr(2'd0, 5'd0, 5'd7, 2'd0, 32'h1234_5678, 32'h0, 32'h0);
    ReadAddrA = 5'd0;
    #2;
    chk("z_en", {31'h0, WB_En_out}, 32'h0);
    tick();
    idle();
    #2;
    chk("z_read", ReadDataA, 32'h0);
    chk("z_cnt", WriteCount_out, 32'd2);
    chk("z_last_en", {31'h0, LastWrEn_out}, 32'h0);
    chk("z_last_addr", {27'h0, LastWrAddr_out}, 32'd31);
    chk("z_last_data", LastWrData_out, 32'h0000_0044);

    // Same-cycle read of the write target, load data via Rt
`ifdef REGFILE_BYPASS_EN
    same_cycle_exp = 32'hCAFE_0001;
`else
    same_cycle_exp = 32'h0;
`endif
    wr(2'd0, 5'd9, 5'd12, 2'd1, 32'h5555_5555, 32'hCAFE_0001, 32'h6666_6666);
    ReadAddrB = 5'd9;
    #2;
    chk("sel_mem_data", WB_Data_out, 32'hCAFE_0001);
    chk("same_cyc_b", ReadDataB, same_cycle_exp);
    tick();
    idle();
    #2;
    chk("after_b", ReadDataB, 32'hCAFE_0001);
    chk("w3_cnt", WriteCount_out, 32'd3);

    // Move SP so the later reset visibly restores it
    wr(2'd1, 5'd0, 5'd29, 2'd0, 32'h0000_1000, 32'h0, 32'h0);
    tick();
    idle();
    ReadAddrA = 5'd29;
    #2;
    chk("sp_moved", ReadDataA, 32'h0000_1000);
    chk("w4_cnt", WriteCount_out, 32'd4);

    // Reset together with a write request
    wr(2'd1, 5'd0, 5'd10, 2'd0, 32'hAAAA_5555, 32'h0, 32'h0);
    reset = 1'b1;
    #2;
    chk("rst_en_indep", {31'h0, WB_En_out}, 32'h1);
    tick();
    reset = 1'b0;
    idle();
    ReadAddrA = 5'd10;
    ReadAddrB = 5'd29;
    #2;
    chk("mid_r10", ReadDataA, 32'h0);
    chk("mid_sp", ReadDataB, 32'h0000_03FC);
    chk("mid_cnt", WriteCount_out, 32'h0);
    chk("mid_last_en", {31'h0, LastWrEn_out}, 32'h0);
    ReadAddrA = 5'd8;
    #1;
    chk("mid_r8", ReadDataA, 32'h0);

    // Counter wrap from a preloaded all-ones value; RegDst=3/MemToReg=3 also map to link/PC+4
    force dut.WriteCount_out = 32'hFFFF_FFFF;
    #1;
    release dut.WriteCount_out;
    #1;
    chk("pre_wrap_cnt", WriteCount_out, 32'hFFFF_FFFF);
    wr(2'd3, 5'd1, 5'd2, 2'd3, 32'h7777_7777, 32'h8888_8888, 32'h0000_0100);
    #1;
    chk("sel3_addr", {27'h0, WB_Addr_out}, 32'd31);
    chk("sel3_data", WB_Data_out, 32'h0000_0100);
    tick();
    idle();
    ReadAddrA = 5'd31;
    #2;
    chk("wrap_cnt", WriteCount_out, 32'h0);
    chk("wrap_last_en", {31'h0, LastWrEn_out}, 32'h1);
    chk("wrap_r31", ReadDataA, 32'h0000_0100);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back stage consumer of the MEM/WB pipeline register outputs, merged with the 32-entry MIPS general register file.
- Selects the write-back data (ALU result, load data, or PC+4 for link) and the destination register (Rt, Rd, or $31), then commits the write on the clock edge.
- Provides two read ports to ID, combinational WB forwarding taps to EX, a registered last-write record, and a commit counter.

Parameters:
- DATA_W, 32, register and datapath width
- NUM_REGS, 32, number of architectural registers (address width is 5 bits)
- LINK_REG, 31, destination register for RegDst 2/3 (jal/jalr link)
- SP_REG, 29, stack-pointer register index
- SP_INIT, 32'h0000_03FC, reset value of SP_REG

Ports:
- clk  in  1  clock, all state updates on the rising edge
- reset  in  1  synchronous active-high reset
- PC_add_4_in  in  32  PC+4 of the retiring instruction
- ALUOut_in  in  32  ALU result
- MemReadData_in  in  32  load data
- Rt_in  in  5  rt field
- Rd_in  in  5  rd field
- RegDst_in  in  2  0=Rt, 1=Rd, 2/3=LINK_REG
- MemToReg_in  in  2  0=ALUOut, 1=MemReadData, 2/3=PC_add_4
- RegWrite_in  in  1  write request
- ReadAddrA  in  5  ID read port A address
- ReadAddrB  in  5  ID read port B address
- ReadDataA  out  32  port A data (combinational)
- ReadDataB  out  32  port B data (combinational)
- WB_Addr_out  out  5  selected destination (combinational)
- WB_Data_out  out  32  selected write data (combinational)
- WB_En_out  out  1  effective write enable (combinational)
- LastWrAddr_out  out  5  registered address of the most recent committed write
- LastWrData_out  out  32  registered data of the most recent committed write
- LastWrEn_out  out  1  a write committed on the previous edge
- WriteCount_out  out  32  count of committed writes

Behaviour:
- Reset is synchronous and active-high. It is sampled only at the rising edge of clk.
- On a reset edge:
  - All registers clear to 0, except SP_REG, which loads SP_INIT.
  - LastWrAddr_out=0, LastWrData_out=0, LastWrEn_out=0, WriteCount_out=0.
  - Any write request in that cycle is discarded.
- Destination select: WB_Addr_out = Rt_in if RegDst_in=0; Rd_in if RegDst_in=1; LINK_REG otherwise.
- Data select: WB_Data_out = ALUOut_in if MemToReg_in=0; MemReadData_in if MemToReg_in=1; PC_add_4_in otherwise.
- Write enable: WB_En_out = RegWrite_in && (WB_Addr_out != 0). It does not depend on reset.
- Commit: on a rising edge with !reset && WB_En_out:
  - regs[WB_Addr_out] <= WB_Data_out.
  - LastWrAddr_out and LastWrData_out update to the written address and data.
  - LastWrEn_out <= 1.
  - WriteCount_out increments by 1 and wraps from FFFF_FFFF to 0.
- No commit: on an edge with !reset && !WB_En_out, LastWrEn_out <= 0. LastWrAddr_out, LastWrData_out and WriteCount_out hold.
- Write to $0 (RegWrite_in=1, destination 0): dropped. No state change, no count, LastWrEn_out <= 0.
- Register $0: always reads 0 and is never stored.
- Read ports: ReadDataX = 0 if ReadAddrX=0, else regs[ReadAddrX]. Both ports are independent and may read the same address.
- Write latency: 1 edge. Without the bypass, a read of the address being written in the same cycle returns the old value.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- With the macro defined: if WB_En_out && ReadAddrX == WB_Addr_out, then ReadDataX = WB_Data_out in the same cycle (write-before-read). This removes the WB→ID hazard.
- Without it: reads return the stored value only, and the hazard unit must stall or forward for one cycle.

Decomposition:
- Shared package holds:
  - RegDst encodings (REGDST_RT=0, REGDST_RD=1, REGDST_LINK=2).
  - MemToReg encodings (MEMTOREG_ALU=0, MEMTOREG_MEM=1, MEMTOREG_PC4=2).
  - Register indices ZERO=0, SP=29, RA=31.
- One natural sub-module is reg_array_2r1w: the storage, the $0 rule, and the bypass. The select muxes, the last-write record and the counter stay in the top level.

Test Plan:
- Reset check: assert reset for 1 edge, then release. ReadAddrA=29 → 0000_03FC. ReadAddrB=5 → 0. WriteCount_out=0, LastWrEn_out=0.
- Select coverage:
  - RegDst=1, Rd=8, MemToReg=0, ALUOut=DEAD_BEEF, RegWrite=1 → after 1 edge reg8=DEAD_BEEF, LastWrAddr_out=8, WriteCount_out=1.
  - RegDst=2, MemToReg=2, PC_add_4=0000_0044 → reg31=0000_0044, WriteCount_out=2.
- $0 protection: RegDst=0, Rt=0, RegWrite=1, data 1234_5678 → ReadAddrA=0 reads 0, WriteCount_out unchanged, LastWrEn_out=0.
- Same-cycle read of the write target: write reg9 with MemToReg=1, MemReadData=CAFE_0001 while ReadAddrB=9, reg9 previously 0.
  - With REGFILE_BYPASS_EN: ReadDataB=CAFE_0001 before the edge.
  - Without it: ReadDataB=0 before the edge and CAFE_0001 after.
- Reset mid-operation: RegWrite=1 to reg10 in the same cycle as reset=1 → reg10=0 after the edge, WriteCount_out=0, SP restored to 0000_03FC.
- Counter wrap: force WriteCount_out to FFFF_FFFF, then do one valid write → WriteCount_out=0 and LastWrEn_out=1.
